// File: rtl/clk_fc_pkg.sv
// rtl/clk_fc_pkg.sv - shared types and defaults for the 320 MHz clock/fast-command failover controller
package clk_fc_pkg;

    localparam int RATE_NOM_DEF = 320000;
    localparam int RATE_TOL_DEF = 1000;

    // Encoding is also the clk_FC_mux status register field value.
    typedef enum logic [2:0] {
        S_INT        = 3'd0,
        S_GUARD_EXT  = 3'd1,
        S_SETTLE_EXT = 3'd2,
        S_EXT        = 3'd3,
        S_GUARD_INT  = 3'd4,
        S_SETTLE_INT = 3'd5
    } state_t;

    function automatic logic state_sel_int(input state_t s);
        return (s == S_INT) || (s == S_GUARD_EXT) || (s == S_SETTLE_INT);
    endfunction

    function automatic logic state_blank(input state_t s);
        return (s != S_INT) && (s != S_EXT);
    endfunction

endpackage

// File: rtl/rate_window_qual.sv
// rtl/rate_window_qual.sv - qualifies clk_ext from clkStopTool rate measurements
module rate_window_qual
    import clk_fc_pkg::*;
#(
    parameter int RATE_W   = 24,
    parameter int RATE_NOM = RATE_NOM_DEF,
    parameter int RATE_TOL = RATE_TOL_DEF,
    parameter int GOOD_N   = 4,
    parameter int BAD_N    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RATE_W-1:0] rate_value,
    input  logic              rate_valid,
    input  logic              ext_stopped,
    output logic              ext_good
);

    localparam int GW = $clog2(GOOD_N + 1);
    localparam int BW = $clog2(BAD_N + 1);
    localparam logic [RATE_W:0] NOM_X = (RATE_W + 1)'(RATE_NOM);
    localparam logic [RATE_W:0] TOL_X = (RATE_W + 1)'(RATE_TOL);

    logic [RATE_W:0] rate_x;
    logic [RATE_W:0] diff;
    logic            in_win;
    logic [GW-1:0]   good_q, good_d;
    logic [BW-1:0]   bad_q, bad_d;
    logic            ext_good_q, ext_good_d;

    always_comb begin
        // One extra bit so a rate below nominal never wraps into the window.
        rate_x     = {1'b0, rate_value};
        diff       = (rate_x >= NOM_X) ? (rate_x - NOM_X) : (NOM_X - rate_x);
        in_win     = (diff <= TOL_X);
        good_d     = good_q;
        bad_d      = bad_q;
        ext_good_d = ext_good_q;
        if (rate_valid) begin
            if (in_win) begin
                good_d = (good_q == GW'(GOOD_N)) ? good_q : good_q + 1'b1;
                bad_d  = '0;
            end else begin
                bad_d  = (bad_q == BW'(BAD_N)) ? bad_q : bad_q + 1'b1;
                good_d = '0;
            end
        end
        if (ext_stopped) begin
            ext_good_d = 1'b0;
        end else if (rate_valid && in_win && (good_d == GW'(GOOD_N))) begin
            ext_good_d = 1'b1;
        end else if (rate_valid && !in_win && (bad_d == BW'(BAD_N))) begin
            ext_good_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_q     <= '0;
            bad_q      <= '0;
            ext_good_q <= 1'b0;
        end else begin
            good_q     <= good_d;
            bad_q      <= bad_d;
            ext_good_q <= ext_good_d;
        end
    end

    assign ext_good = ext_good_q;

endmodule

// File: rtl/clk_failover_ctrl.sv
// rtl/clk_failover_ctrl.sv - sequences glitch-safe clk_int/clk_ext switchovers with fast-command blanking
module clk_failover_ctrl
    import clk_fc_pkg::*;
#(
    parameter int RATE_W     = 24,
    parameter int RATE_NOM   = RATE_NOM_DEF,
    parameter int RATE_TOL   = RATE_TOL_DEF,
    parameter int GOOD_N     = 4,
    parameter int BAD_N      = 2,
    parameter int GUARD_CYC  = 16,
    parameter int SETTLE_CYC = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic [RATE_W-1:0] rate_value,
    input  logic              rate_valid,
    input  logic              ext_stopped,
    input  logic              auto_en,
    input  logic              force_int,
    output logic              clk_int_sel,
    output logic              fc_blank,
    output logic              ext_good,
    output logic [2:0]        state_out,
    output logic [CNT_W-1:0]  switch_cnt,
    output logic              switch_pulse
);

    localparam int TMR_MAX = (GUARD_CYC > SETTLE_CYC) ? GUARD_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] GUARD_LD  = TMR_W'(GUARD_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               sel_q, sel_d;
    logic               blank_q, blank_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pulse_q, pulse_d;
    logic               want_ext;
    logic               done;

    rate_window_qual #(
        .RATE_W   (RATE_W),
        .RATE_NOM (RATE_NOM),
        .RATE_TOL (RATE_TOL),
        .GOOD_N   (GOOD_N),
        .BAD_N    (BAD_N)
    ) u_qual (
        .clk         (clk),
        .rst         (reset_in),
        .rate_value  (rate_value),
        .rate_valid  (rate_valid),
        .ext_stopped (ext_stopped),
        .ext_good    (ext_good)
    );

    assign want_ext = auto_en & ~force_int & ext_good & ~ext_stopped;

    always_comb begin
        state_d = state_q;
        timer_d = (timer_q == '0) ? timer_q : timer_q - 1'b1;
        done    = 1'b0;
        case (state_q)
            S_INT: begin
                if (want_ext) begin
                    state_d = S_GUARD_EXT;
                    timer_d = GUARD_LD;
                end
            end
            S_GUARD_EXT: begin
                if (!want_ext) begin
                    state_d = S_INT;
                end else if (timer_q == '0) begin
                    state_d = S_SETTLE_EXT;
                    timer_d = SETTLE_LD;
                end
            end
            S_SETTLE_EXT: begin
                if (ext_stopped) begin
                    state_d = S_SETTLE_INT;
                    timer_d = SETTLE_LD;
                end else if (!want_ext) begin
                    state_d = S_GUARD_INT;
                    timer_d = GUARD_LD;
                end else if (timer_q == '0) begin
                    state_d = S_EXT;
                    done    = 1'b1;
                end
            end
            S_EXT: begin
                // A stopped clk_ext cannot be drained, so skip the guard.
                if (ext_stopped) begin
                    state_d = S_SETTLE_INT;
                    timer_d = SETTLE_LD;
                end else if (!want_ext) begin
                    state_d = S_GUARD_INT;
                    timer_d = GUARD_LD;
                end
            end
            S_GUARD_INT: begin
                if (ext_stopped || (timer_q == '0)) begin
                    state_d = S_SETTLE_INT;
                    timer_d = SETTLE_LD;
                end
            end
            S_SETTLE_INT: begin
                if (timer_q == '0) begin
                    state_d = S_INT;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = S_INT;
            end
        endcase
        sel_d   = state_sel_int(state_d);
        blank_d = state_blank(state_d);
        pulse_d = done;
        cnt_d   = (done && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_INT;
            timer_q <= '0;
            sel_q   <= 1'b1;
            blank_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign clk_int_sel  = sel_q;
    assign fc_blank     = blank_q;
    assign state_out    = state_q;
    assign switch_cnt   = cnt_q;
    assign switch_pulse = pulse_q;

endmodule
